datapath_xyz: RTL and testbench

- Register datapath directly downstream of the step-control decoder. Consumes its per-step control codes and executes them on clock edges.
- Contains three N-bit registers X, Y and Z. Y has shift capability.
- Contains a combinational add/subtract ULA whose result is Y's load source.
- Drives Z to the display/output stage, plus status flags for the upstream sequencer.

---
 rtl/datapath_xyz_if.sv | 25 ++
 rtl/datapath_xyz.sv | 87 ++++++++
 tb/tb_datapath_xyz.sv | 130 +++++++++++++
 3 files changed

// File: rtl/datapath_xyz_if.sv
// Control/data bundle between the step sequencer and the X/Y/Z register datapath.
interface datapath_xyz_if #(parameter int N = 4);
  logic [N-1:0] din;
  logic [1:0]   auxX;
  logic [2:0]   auxY;
  logic [1:0]   auxZ;
  logic         auxULA;
  logic [N-1:0] x_q;
  logic [N-1:0] y_q;
  logic [N-1:0] z_q;
  logic [N-1:0] ula_out;
  logic         carry;
  logic         zero;
  logic         z_valid;

  modport master (
    output din, auxX, auxY, auxZ, auxULA,
    input  x_q, y_q, z_q, ula_out, carry, zero, z_valid
  );

  modport slave (
    input  din, auxX, auxY, auxZ, auxULA,
    output x_q, y_q, z_q, ula_out, carry, zero, z_valid
  );
endinterface

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath with add/sub ULA feeding Y; Z carries the result out.
// DATAPATH_ARITH_SHIFT_EN makes Y shift-right arithmetic instead of logical.
module datapath_xyz #(
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  datapath_xyz_if.slave bus
);

  logic [N-1:0] x_r, y_r, z_r;
  logic         carry_r, zero_r, zv_r;
  logic [N:0]   sum, dif;
  logic [N-1:0] ula;
  logic         carry_n;
  logic         msb_fill;

  // (N+1)-bit ops: bit N is the carry for add and the borrow for sub.
  assign sum = {1'b0, y_r} + {1'b0, x_r};
  assign dif = {1'b0, y_r} - {1'b0, x_r};

  always_comb begin
    if (bus.auxULA) begin
      ula     = dif[N-1:0];
      carry_n = dif[N];
    end else begin
      ula     = sum[N-1:0];
      carry_n = sum[N];
    end
  end

`ifdef DATAPATH_ARITH_SHIFT_EN
  assign msb_fill = y_r[N-1];
`else
  assign msb_fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      carry_r <= 1'b0;
      zero_r  <= 1'b1;
      zv_r    <= 1'b0;
    end else begin
      case (bus.auxX)
        2'b00:   x_r <= '0;
        2'b01:   x_r <= bus.din;
        default: x_r <= x_r;
      endcase

      case (bus.auxY)
        3'b000: begin
          y_r     <= '0;
          carry_r <= 1'b0;
          zero_r  <= 1'b1;
        end
        3'b001: begin
          y_r     <= ula;
          carry_r <= carry_n;
          zero_r  <= (ula == '0);
        end
        3'b011:  y_r <= {y_r[N-2:0], 1'b0};
        3'b100:  y_r <= {msb_fill, y_r[N-1:1]};
        default: y_r <= y_r;
      endcase

      case (bus.auxZ)
        2'b00:   z_r <= '0;
        2'b01:   z_r <= y_r;
        default: z_r <= z_r;
      endcase

      zv_r <= (bus.auxZ == 2'b01);
    end
  end

  assign bus.x_q     = x_r;
  assign bus.y_q     = y_r;
  assign bus.z_q     = z_r;
  assign bus.ula_out = ula;
  assign bus.carry   = carry_r;
  assign bus.zero    = zero_r;
  assign bus.z_valid = zv_r;

endmodule

// File: tb/tb_datapath_xyz.sv
// Directed table-driven bench for datapath_xyz (N=4) with a few hand sequences.
module tb_datapath_xyz;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  datapath_xyz_if #(.N(N)) bus ();
  datapath_xyz #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef DATAPATH_ARITH_SHIFT_EN
  localparam logic [3:0] SHR_A  = 4'd13;
  localparam logic [3:0] SHR_AU = 4'd7;
`else
  localparam logic [3:0] SHR_A  = 4'd5;
  localparam logic [3:0] SHR_AU = 4'd15;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [1:0] ax;
    logic [2:0] ay;
    logic [1:0] az;
    logic       au;
    logic [3:0] ex, ey, ez, eu;
    logic       ec, ezr, ezv;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] din, input logic [1:0] ax,
                     input logic [2:0] ay, input logic [1:0] az, input logic au,
                     input logic [3:0] ex, input logic [3:0] ey, input logic [3:0] ez,
                     input logic [3:0] eu, input logic ec, input logic ezr, input logic ezv);
    vec_t v;
    v.rst = r; v.din = din; v.ax = ax; v.ay = ay; v.az = az; v.au = au;
    v.ex = ex; v.ey = ey; v.ez = ez; v.eu = eu; v.ec = ec; v.ezr = ezr; v.ezv = ezv;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] din, input logic [1:0] ax,
                       input logic [2:0] ay, input logic [1:0] az, input logic au);
    rst = r; bus.din = din; bus.auxX = ax; bus.auxY = ay; bus.auxZ = az; bus.auxULA = au;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                           input logic [3:0] ez, input logic ec, input logic ezr,
                           input logic ezv);
    chk({tag, ".x"}, 8'(bus.x_q), 8'(ex));
    chk({tag, ".y"}, 8'(bus.y_q), 8'(ey));
    chk({tag, ".z"}, 8'(bus.z_q), 8'(ez));
    chk({tag, ".carry"}, 8'(bus.carry), 8'(ec));
    chk({tag, ".zero"}, 8'(bus.zero), 8'(ezr));
    chk({tag, ".zvalid"}, 8'(bus.z_valid), 8'(ezv));
  endtask

  initial begin
    //   rst din  X     Y       Z     U    x  y  z  ula  c  zr zv
    add(0, 3, 2'b01, 3'b000, 2'b10, 0,  3, 0, 0,  3,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  3, 3, 0,  6,  0, 0, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  3, 6, 0,  9,  0, 0, 0);
    add(0, 9, 2'b01, 3'b000, 2'b10, 0,  9, 0, 0,  9,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  9, 9, 0,  2,  0, 0, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  9, 2, 0, 11,  1, 0, 0);
    add(0, 2, 2'b01, 3'b010, 2'b10, 1,  2, 2, 0,  0,  1, 0, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 1,  2, 0, 0, 14,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 1,  2,14, 0, 12,  1, 0, 0);
    add(0, 5, 2'b01, 3'b000, 2'b10, 0,  5, 0, 0,  5,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  5, 5, 0, 10,  0, 0, 0);
    add(0, 1, 2'b01, 3'b010, 2'b10, 0,  1, 5, 0,  6,  0, 0, 0);
    add(0, 0, 2'b10, 3'b001, 2'b01, 0,  1, 6, 5,  7,  0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 2'b10, 0,  1, 6, 5,  7,  0, 0, 0);
    add(0, 0, 2'b10, 3'b010, 2'b01, 0,  1, 6, 6,  7,  0, 0, 1);
    add(0, 0, 2'b10, 3'b010, 2'b01, 0,  1, 6, 6,  7,  0, 0, 1);
    add(0, 9, 2'b11, 3'b101, 2'b11, 0,  1, 6, 6,  7,  0, 0, 0);
    add(0, 0, 2'b10, 3'b010, 2'b00, 0,  1, 6, 0,  7,  0, 0, 0);
    add(0,10, 2'b01, 3'b000, 2'b10, 0, 10, 0, 0, 10,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0, 10,10, 0,  4,  0, 0, 0);
    add(0, 0, 2'b10, 3'b100, 2'b10, 0, 10,SHR_A,0,SHR_AU,0,0,0);
    add(0, 0, 2'b10, 3'b011, 2'b10, 0, 10,10, 0,  4,  0, 0, 0);
    add(0, 0, 2'b10, 3'b011, 2'b10, 0, 10, 4, 0, 14,  0, 0, 0);
    add(0, 0, 2'b10, 3'b111, 2'b10, 0, 10, 4, 0, 14,  0, 0, 0);
    add(0, 0, 2'b10, 3'b100, 2'b10, 0, 10, 2, 0, 12,  0, 0, 0);
    add(0, 7, 2'b01, 3'b000, 2'b10, 0,  7, 0, 0,  7,  0, 1, 0);
    add(0, 0, 2'b10, 3'b001, 2'b10, 0,  7, 7, 0, 14,  0, 0, 0);
    add(1, 5, 2'b01, 3'b001, 2'b01, 0,  0, 0, 0,  0,  0, 1, 0);
    add(0, 2, 2'b01, 3'b010, 2'b10, 0,  2, 0, 0,  2,  0, 1, 0);

    // Reset held two cycles while controls toggle randomly
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 4'($urandom), 2'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk_state($sformatf("reset%0d", i), 0, 0, 0, 0, 1, 0);
    end

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].din, tv[i].ax, tv[i].ay, tv[i].az, tv[i].au);
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), tv[i].ex, tv[i].ey, tv[i].ez, tv[i].ec, tv[i].ezr, tv[i].ezv);
      chk($sformatf("v%0d.ula", i), 8'(bus.ula_out), 8'(tv[i].eu));
    end

    // ULA is combinational on auxULA with x=2, y=0 held
    @(negedge clk);
    drive(1'b0, 0, 2'b10, 3'b010, 2'b10, 1'b1);
    #1 chk("ula_sub_comb", 8'(bus.ula_out), 8'd14);
    bus.auxULA = 1'b0;
    #1 chk("ula_add_comb", 8'(bus.ula_out), 8'd2);
    @(posedge clk); #1;
    chk_state("hold_end", 2, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
